pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage RV32 pipeline. It drives the `en` (hold) and `clc` (bubble) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC enable. It covers three cases:
- load-use hazards,
- taken-branch redirects from EX,
- a multi-cycle data-memory handshake in MEM.

It also keeps a saturating stall counter and a memory-timeout error flag.

---
 rtl/pipe_ctrl_pkg.sv | 40 ++++
 rtl/load_use_detect.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    localparam int REG_ADDR_W      = 5;
    localparam int DEF_MEM_TIMEOUT = 16;
    localparam int DEF_CNT_W       = 32;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } ctrl_state_e;

    // One bundle for every register control the controller drives.
    typedef struct packed {
        logic dmem_req;
        logic pc_en;
        logic ifid_en;
        logic ifid_clc;
        logic idex_en;
        logic idex_clc;
        logic exmem_en;
        logic exmem_clc;
        logic memwb_en;
        logic memwb_clc;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET  = '{dmem_req: 1'b0, pc_en: 1'b0,
                                      ifid_en: 1'b1, ifid_clc: 1'b1,
                                      idex_en: 1'b1, idex_clc: 1'b1,
                                      exmem_en: 1'b1, exmem_clc: 1'b1,
                                      memwb_en: 1'b1, memwb_clc: 1'b1};
    localparam ctrl_t CTRL_RUN    = '{dmem_req: 1'b0, pc_en: 1'b1,
                                      ifid_en: 1'b1, ifid_clc: 1'b0,
                                      idex_en: 1'b1, idex_clc: 1'b0,
                                      exmem_en: 1'b1, exmem_clc: 1'b0,
                                      memwb_en: 1'b1, memwb_clc: 1'b0};
    localparam ctrl_t CTRL_FROZEN = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detection between the ID and EX stages.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_is_load,
    output logic                  hazard
);

    logic rd_live;
    logic rs1_hit;
    logic rs2_hit;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign rd_live = ex_is_load && (ex_rd != '0);
    assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
    assign hazard  = rd_live && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: memory freeze, branch flush,
// load-use bubble, plus a saturating stall counter and sticky memory-timeout flag.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_is_load,
    input  logic                  ex_br_taken,
    input  logic                  mem_req,
    input  logic                  mem_ack,
    output logic                  dmem_req,
    output logic                  pc_en,
    output logic                  ifid_en,
    output logic                  ifid_clc,
    output logic                  idex_en,
    output logic                  idex_clc,
    output logic                  exmem_en,
    output logic                  exmem_clc,
    output logic                  memwb_en,
    output logic                  memwb_clc,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic                  mem_err,
    output logic [1:0]            dbg_state
);

    localparam logic [1:0] RUN      = ST_RUN;
    localparam logic [1:0] MEM_WAIT = ST_MEM_WAIT;
    localparam logic [1:0] ERR      = ST_ERR;
    localparam int         WAIT_W   = $clog2(MEM_TIMEOUT + 1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              hazard;
    logic              mem_stall;
    logic              req_out;
    ctrl_t             ctrl;

    load_use_detect u_load_use_detect (
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .ex_rd      (ex_rd),
        .ex_is_load (ex_is_load),
        .hazard     (hazard)
    );

    // Handshake: dmem_req is a level held from the first request cycle until the
    // cycle mem_ack is seen; an access completes in the cycle where both are high.
    // mem_ack with no outstanding request carries no meaning and is ignored.
    always_comb begin
        mem_stall = 1'b1;
        req_out   = 1'b0;
        case (state)
            RUN: begin
                req_out   = mem_req;
                mem_stall = mem_req && !mem_ack;
            end
            MEM_WAIT: begin
                req_out   = 1'b1;
                mem_stall = !mem_ack;
            end
            default: begin
                req_out   = 1'b0;
                mem_stall = 1'b1;
            end
        endcase
    end

    // The wait count reaching MEM_TIMEOUT inside MEM_WAIT declares the memory dead.
    always_comb begin
        state_nxt = state;
        wait_nxt  = wait_cnt;
        case (state)
            RUN: begin
                if (mem_req && !mem_ack) begin
                    state_nxt = MEM_WAIT;
                    wait_nxt  = '0;
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    state_nxt = RUN;
                end else begin
                    wait_nxt = wait_cnt + WAIT_W'(1);
                    if (wait_nxt == WAIT_W'(MEM_TIMEOUT)) begin
                        state_nxt = ERR;
                    end
                end
            end
            ERR: begin
                state_nxt = ERR;
            end
            default: begin
                state_nxt = RUN;
                wait_nxt  = '0;
            end
        endcase
    end

    // Priority: reset, memory freeze, branch flush (ID is wrong-path), load-use bubble.
    always_comb begin
        ctrl = CTRL_RUN;
        if (!rst_n) begin
            ctrl = CTRL_RESET;
        end else if (mem_stall) begin
            ctrl = CTRL_FROZEN;
        end else if (ex_br_taken) begin
            ctrl          = CTRL_RUN;
            ctrl.ifid_clc = 1'b1;
            ctrl.idex_clc = 1'b1;
        end else if (hazard) begin
            ctrl          = CTRL_RUN;
            ctrl.pc_en    = 1'b0;
            ctrl.ifid_en  = 1'b0;
            ctrl.idex_clc = 1'b1;
        end
        if (rst_n) begin
            ctrl.dmem_req = req_out;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            mem_err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (!ctrl.pc_en && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (state_nxt == ERR) begin
                mem_err <= 1'b1;
            end
        end
    end

    assign dmem_req  = ctrl.dmem_req;
    assign pc_en     = ctrl.pc_en;
    assign ifid_en   = ctrl.ifid_en;
    assign ifid_clc  = ctrl.ifid_clc;
    assign idex_en   = ctrl.idex_en;
    assign idex_clc  = ctrl.idex_clc;
    assign exmem_en  = ctrl.exmem_en;
    assign exmem_clc = ctrl.exmem_clc;
    assign memwb_en  = ctrl.memwb_en;
    assign memwb_clc = ctrl.memwb_clc;
    assign dbg_state = state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: per-cycle reference model feeding an expected queue,
// plus scenario tasks with their own targeted checks.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int TMO = 4;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_is_load, ex_br_taken, mem_req, mem_ack;

  logic        dmem_req, pc_en, ifid_en, ifid_clc, idex_en, idex_clc;
  logic        exmem_en, exmem_clc, memwb_en, memwb_clc, mem_err;
  logic [31:0] stall_cnt;
  logic [1:0]  dbg_state;

  logic        s_dmem_req, s_pc_en, s_ifid_en, s_ifid_clc, s_idex_en, s_idex_clc;
  logic        s_exmem_en, s_exmem_clc, s_memwb_en, s_memwb_clc, s_mem_err;
  logic [2:0]  s_stall_cnt;
  logic [1:0]  s_dbg_state;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken), .mem_req(mem_req),
    .mem_ack(mem_ack), .dmem_req(dmem_req), .pc_en(pc_en), .ifid_en(ifid_en),
    .ifid_clc(ifid_clc), .idex_en(idex_en), .idex_clc(idex_clc),
    .exmem_en(exmem_en), .exmem_clc(exmem_clc), .memwb_en(memwb_en),
    .memwb_clc(memwb_clc), .stall_cnt(stall_cnt), .mem_err(mem_err),
    .dbg_state(dbg_state)
  );

  pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_br_taken(ex_br_taken), .mem_req(mem_req),
    .mem_ack(mem_ack), .dmem_req(s_dmem_req), .pc_en(s_pc_en), .ifid_en(s_ifid_en),
    .ifid_clc(s_ifid_clc), .idex_en(s_idex_en), .idex_clc(s_idex_clc),
    .exmem_en(s_exmem_en), .exmem_clc(s_exmem_clc), .memwb_en(s_memwb_en),
    .memwb_clc(s_memwb_clc), .stall_cnt(s_stall_cnt), .mem_err(s_mem_err),
    .dbg_state(s_dbg_state)
  );

  int vectors = 0;
  int errors  = 0;

  // entry: {ctrl[9:0], stall[31:0], sat_stall[2:0], mem_err, state[1:0]}
  logic [47:0] exp_q[$];

  // reference model state: m_* holds for the current cycle, n_* after the next edge
  logic [1:0]  m_state, n_state;
  int          m_wait, n_wait;
  int unsigned m_stall, n_stall;
  logic        m_err, n_err;

  // driver: one clock cycle of stimulus; pushes what the DUT must show this cycle
  task automatic apply(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic ld, input logic br, input logic req, input logic ack);
    logic [9:0] e;
    logic       hz, frz, dreq;
    logic [2:0] sat;
    @(posedge clk);
    #1;
    m_state = n_state; m_wait = n_wait; m_stall = n_stall; m_err = n_err;
    rst_n = r; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = rd; ex_is_load = ld; ex_br_taken = br; mem_req = req; mem_ack = ack;
    hz = ld && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    if (!r) begin
      e = 10'b00_11111111;
    end else begin
      frz  = (m_state == ST_ERR) || (m_state == ST_MEM_WAIT && !ack) ||
             (m_state == ST_RUN && req && !ack);
      dreq = (m_state == ST_MEM_WAIT) ? 1'b1 : (m_state == ST_ERR) ? 1'b0 : req;
      if (frz)     e = {dreq, 9'b0};
      else if (br) e = {dreq, 1'b1, 8'b11_11_10_10};
      else if (hz) e = {dreq, 1'b0, 8'b00_11_10_10};
      else         e = {dreq, 1'b1, 8'b10_10_10_10};
    end
    sat = (m_stall > 7) ? 3'd7 : m_stall[2:0];
    exp_q.push_back({e, m_stall, sat, m_err, m_state});
    if (!r) begin
      n_state = ST_RUN; n_wait = 0; n_stall = 0; n_err = 1'b0;
    end else begin
      n_state = m_state; n_wait = m_wait; n_err = m_err;
      n_stall = (e[8] == 1'b0) ? m_stall + 1 : m_stall;
      case (m_state)
        ST_RUN: if (req && !ack) begin n_state = ST_MEM_WAIT; n_wait = 0; end
        ST_MEM_WAIT: begin
          if (ack) n_state = ST_RUN;
          else begin
            n_wait = m_wait + 1;
            if (n_wait == TMO) begin n_state = ST_ERR; n_err = 1'b1; end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic idle();
    apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // scoreboard: compare every queued expectation mid-cycle
  always @(negedge clk) begin : sb
    logic [47:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if ({dmem_req, pc_en, ifid_en, ifid_clc, idex_en, idex_clc, exmem_en, exmem_clc,
           memwb_en, memwb_clc} !== e[47:38]) begin
        errors++;
        $display("FAIL sb_ctrl @%0t: got %b want %b", $time,
                 {dmem_req, pc_en, ifid_en, ifid_clc, idex_en, idex_clc, exmem_en,
                  exmem_clc, memwb_en, memwb_clc}, e[47:38]);
      end
      vectors++;
      if (stall_cnt !== e[37:6]) begin
        errors++;
        $display("FAIL sb_stall_cnt @%0t: got %0d want %0d", $time, stall_cnt, e[37:6]);
      end
      vectors++;
      if (s_stall_cnt !== e[5:3]) begin
        errors++;
        $display("FAIL sb_sat_cnt @%0t: got %0d want %0d", $time, s_stall_cnt, e[5:3]);
      end
      vectors++;
      if (mem_err !== e[2]) begin
        errors++;
        $display("FAIL sb_mem_err @%0t: got %b want %b", $time, mem_err, e[2]);
      end
      vectors++;
      if (dbg_state !== e[1:0]) begin
        errors++;
        $display("FAIL sb_state @%0t: got %0d want %0d", $time, dbg_state, e[1:0]);
      end
    end
  end

  task automatic test_reset();
    do_reset();
    #1;
    vectors++;
    if ({pc_en, dmem_req, ifid_clc, idex_clc, exmem_clc, memwb_clc, ifid_en, memwb_en} !== 8'b00111111) begin
      errors++;
      $display("FAIL reset_forced: got %b want 00111111",
               {pc_en, dmem_req, ifid_clc, idex_clc, exmem_clc, memwb_clc, ifid_en, memwb_en});
    end
    idle();
    #1;
    vectors++;
    if (stall_cnt !== 32'd0 || mem_err !== 1'b0 || dbg_state !== ST_RUN) begin
      errors++;
      $display("FAIL reset_state: got cnt=%0d err=%b st=%0d want 0 0 0", stall_cnt, mem_err, dbg_state);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    apply(1'b1, 5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    vectors++;
    if (pc_en !== 1'b0 || ifid_en !== 1'b0 || idex_clc !== 1'b1 || exmem_en !== 1'b1) begin
      errors++;
      $display("FAIL lu_resp: got pc=%b ifid_en=%b idex_clc=%b exmem_en=%b want 0 0 1 1",
               pc_en, ifid_en, idex_clc, exmem_en);
    end
    idle();
    #1;
    vectors++;
    if (stall_cnt !== 32'd1 || pc_en !== 1'b1) begin
      errors++;
      $display("FAIL lu_one_cycle: got cnt=%0d pc=%b want 1 1", stall_cnt, pc_en);
    end
    apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    vectors++;
    if (pc_en !== 1'b1 || idex_clc !== 1'b0) begin
      errors++;
      $display("FAIL lu_x0: got pc=%b idex_clc=%b want 1 0", pc_en, idex_clc);
    end
    apply(1'b1, 5'd9, 5'd2, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);  // rs1 match
    apply(1'b1, 5'd9, 5'd2, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);  // rs1 unused
    apply(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0);  // not a load
    idle();
    #1;
    vectors++;
    if (stall_cnt !== 32'd2) begin
      errors++;
      $display("FAIL lu_count: got %0d want 2", stall_cnt);
    end
  endtask

  task automatic test_branch();
    do_reset();
    apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    vectors++;
    if (ifid_clc !== 1'b1 || idex_clc !== 1'b1 || pc_en !== 1'b1 || memwb_en !== 1'b1) begin
      errors++;
      $display("FAIL br_flush: got ifid_clc=%b idex_clc=%b pc=%b want 1 1 1", ifid_clc, idex_clc, pc_en);
    end
    apply(1'b1, 5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    vectors++;
    if (ifid_clc !== 1'b1 || pc_en !== 1'b1 || ifid_en !== 1'b1) begin
      errors++;
      $display("FAIL br_over_lu: got ifid_clc=%b pc=%b ifid_en=%b want 1 1 1", ifid_clc, pc_en, ifid_en);
    end
    idle();
    #1;
    vectors++;
    if (stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL br_no_stall: got %0d want 0", stall_cnt);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      #1;
      vectors++;
      if (dmem_req !== 1'b1 || pc_en !== 1'b0 || exmem_en !== 1'b0) begin
        errors++;
        $display("FAIL mw_frozen[%0d]: got req=%b pc=%b exmem_en=%b want 1 0 0", i, dmem_req, pc_en, exmem_en);
      end
    end
    apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1;
    vectors++;
    if (pc_en !== 1'b1 || dmem_req !== 1'b1 || memwb_en !== 1'b1) begin
      errors++;
      $display("FAIL mw_release: got pc=%b req=%b memwb_en=%b want 1 1 1", pc_en, dmem_req, memwb_en);
    end
    apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);  // single-cycle access
    apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);  // stray ack
    #1;
    vectors++;
    if (dmem_req !== 1'b0 || pc_en !== 1'b1) begin
      errors++;
      $display("FAIL mw_stray_ack: got req=%b pc=%b want 0 1", dmem_req, pc_en);
    end
    idle();
    #1;
    vectors++;
    if (stall_cnt !== 32'd3 || dbg_state !== ST_RUN) begin
      errors++;
      $display("FAIL mw_count: got cnt=%0d st=%0d want 3 0", stall_cnt, dbg_state);
    end
  endtask

  task automatic test_branch_in_freeze();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      #1;
      vectors++;
      if (ifid_clc !== 1'b0 || idex_clc !== 1'b0 || pc_en !== 1'b0) begin
        errors++;
        $display("FAIL bf_hold[%0d]: got ifid_clc=%b idex_clc=%b pc=%b want 0 0 0", i, ifid_clc, idex_clc, pc_en);
      end
    end
    apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    vectors++;
    if (ifid_clc !== 1'b1 || idex_clc !== 1'b1 || pc_en !== 1'b1) begin
      errors++;
      $display("FAIL bf_release_flush: got ifid_clc=%b idex_clc=%b pc=%b want 1 1 1", ifid_clc, idex_clc, pc_en);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    apply(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    vectors++;
    if (dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL rmw_drop: got req=%b want 0", dmem_req);
    end
    idle();
    #1;
    vectors++;
    if (dbg_state !== ST_RUN || pc_en !== 1'b1 || stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL rmw_after: got st=%0d pc=%b cnt=%0d want 0 1 0", dbg_state, pc_en, stall_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      apply(($urandom_range(0, 99) >= 3), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 20),
            ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 60));
    end
  endtask

  task automatic test_timeout_saturation();
    int first_err;
    first_err = -1;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      apply(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, (i > 8));
      #1;
      if (mem_err === 1'b1 && first_err < 0) first_err = i;
    end
    vectors++;
    if (first_err != TMO + 1) begin
      errors++;
      $display("FAIL to_latency: got mem_err first at cycle %0d want %0d", first_err, TMO + 1);
    end
    vectors++;
    if (dbg_state !== ST_ERR || dmem_req !== 1'b0 || pc_en !== 1'b0 || memwb_en !== 1'b0) begin
      errors++;
      $display("FAIL to_err_frozen: got st=%0d req=%b pc=%b memwb_en=%b want 2 0 0 0",
               dbg_state, dmem_req, pc_en, memwb_en);
    end
    vectors++;
    if (stall_cnt !== 32'd12 || s_stall_cnt !== 3'd7) begin
      errors++;
      $display("FAIL to_sat: got cnt=%0d sat=%0d want 12 7", stall_cnt, s_stall_cnt);
    end
    do_reset();
    idle();
    #1;
    vectors++;
    if (mem_err !== 1'b0 || dbg_state !== ST_RUN || s_stall_cnt !== 3'd0) begin
      errors++;
      $display("FAIL to_cleared: got err=%b st=%0d sat=%0d want 0 0 0", mem_err, dbg_state, s_stall_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = '0; ex_is_load = 1'b0; ex_br_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    n_state = ST_RUN; n_wait = 0; n_stall = 0; n_err = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_branch_in_freeze();
    test_reset_mid_wait();
    test_random();
    test_timeout_saturation();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
